mc_ctrl: RTL and testbench

Multicycle control unit for the 32-bit MIPS-subset CPU. It drives every control input of the datapath and consumes its `instr`, `zero` and `more` outputs. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back steps. It sits beside the datapath in the CPU top level.

---
 rtl/mc_pkg.sv | 80 ++++++++
 rtl/mc_decode.sv | 71 +++++++
 rtl/mc_ctrl.sv | 146 ++++++++++++++
 tb/tb_mc_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcodes, state and control-field encodings for the multicycle control unit
package mc_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JREXE  = 4'd10,
    S_JR     = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_RALU    = 4'd0,
    C_IALU    = 4'd1,
    C_LOAD    = 4'd2,
    C_STORE   = 4'd3,
    C_BRANCH  = 4'd4,
    C_J       = 4'd5,
    C_JAL     = 4'd6,
    C_JR      = 4'd7,
    C_ILLEGAL = 4'd8
  } cls_t;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_DR  = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BGTZ = 2'b10;

  localparam logic [1:0] JMP_NONE   = 2'b00;
  localparam logic [1:0] JMP_TARGET = 2'b01;
  localparam logic [1:0] JMP_REG    = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier with per-instruction ALU/extender controls
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [1:0] aluop,
  output logic [1:0] extop,
  output logic [1:0] branch
);

  // Map opcode/funct to an instruction class; anything unrecognised is illegal and runs as a NOP
  always_comb begin
    cls    = C_ILLEGAL;
    aluop  = ALU_ADD;
    extop  = EXT_ZERO;
    branch = BR_NONE;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = C_RALU;
          FN_SUBU: begin
            cls   = C_RALU;
            aluop = ALU_SUB;
          end
          FN_SLT: begin
            cls   = C_RALU;
            aluop = ALU_SLT;
          end
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDIU: begin
        cls   = C_IALU;
        extop = EXT_SIGN;
      end
      OP_ORI: begin
        cls   = C_IALU;
        aluop = ALU_OR;
      end
      OP_LUI: begin
        cls   = C_IALU;
        extop = EXT_LUI;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        cls   = C_LOAD;
        extop = EXT_SIGN;
      end
      OP_SW, OP_SB, OP_SH: begin
        cls   = C_STORE;
        extop = EXT_SIGN;
      end
      OP_BEQ: begin
        cls    = C_BRANCH;
        aluop  = ALU_SUB;
        branch = BR_BEQ;
      end
      OP_BGTZ: begin
        cls    = C_BRANCH;
        aluop  = ALU_SUB;
        branch = BR_BGTZ;
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - Moore FSM sequencing fetch/decode/execute/memory/write-back for the multicycle datapath
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        more,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  regdst,
  output logic        alusrc,
  output logic [1:0]  memtoreg,
  output logic        regwe,
  output logic        memwe,
  output logic [1:0]  branch,
  output logic [1:0]  jump,
  output logic [1:0]  extop,
  output logic [1:0]  aluop,
  output logic        turn,
  output logic [3:0]  state
);

  state_t     state_q, state_n;
  cls_t       cls;
  logic [1:0] dec_aluop, dec_extop, dec_branch;
  logic       pc_wr, ir_wr, reg_we, mem_we;

  // Operand fields and branch flags belong to the datapath; the FSM only looks at op/funct
  logic unused_inputs;
  assign unused_inputs = ^{instr[25:6], zero, more};

  mc_decode u_decode (
    .op     (instr[31:26]),
    .funct  (instr[5:0]),
    .cls    (cls),
    .aluop  (dec_aluop),
    .extop  (dec_extop),
    .branch (dec_branch)
  );

  // State register; reset returns to FETCH so the instruction restarts at the reset PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_n;
  end

  // Next-state and Moore output decode from the current state and latched instruction
  always_comb begin
    state_n  = S_FETCH;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    regdst   = REGDST_RT;
    alusrc   = 1'b0;
    memtoreg = MEMTOREG_ALU;
    branch   = BR_NONE;
    jump     = JMP_NONE;
    extop    = EXT_ZERO;
    aluop    = ALU_ADD;
    turn     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_RALU, C_IALU:  state_n = S_EXE;
          C_LOAD, C_STORE: state_n = S_MEMADR;
          C_BRANCH:        state_n = S_BRANCH;
          C_J, C_JAL:      state_n = S_JUMP;
          C_JR:            state_n = S_JREXE;
          default:         state_n = S_FETCH;
        endcase
      end
      S_EXE: begin
        aluop   = dec_aluop;
        extop   = dec_extop;
        alusrc  = (cls == C_IALU);
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        aluop   = dec_aluop;
        extop   = dec_extop;
        alusrc  = (cls == C_IALU);
        reg_we  = 1'b1;
        regdst  = (cls == C_RALU) ? REGDST_RD : REGDST_RT;
        state_n = S_FETCH;
      end
      S_MEMADR: begin
        aluop   = ALU_ADD;
        alusrc  = 1'b1;
        extop   = EXT_SIGN;
        state_n = (cls == C_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMWR: begin
        mem_we  = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMRD: state_n = S_MEMWB;
      S_MEMWB: begin
        reg_we   = 1'b1;
        memtoreg = MEMTOREG_DR;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        aluop   = ALU_SUB;
        branch  = dec_branch;
        pc_wr   = 1'b1;
        turn    = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        jump  = JMP_TARGET;
        pc_wr = 1'b1;
        turn  = 1'b1;
        if (cls == C_JAL) begin
          reg_we   = 1'b1;
          regdst   = REGDST_RA;
          memtoreg = MEMTOREG_PC;
        end
        state_n = S_FETCH;
      end
      S_JREXE: state_n = S_JR;
      S_JR: begin
        jump    = JMP_REG;
        pc_wr   = 1'b1;
        turn    = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Commit enables are gated by reset so an aborted instruction never writes
  assign PCWr  = pc_wr  & rst;
  assign IRWr  = ir_wr  & rst;
  assign regwe = reg_we & rst;
  assign memwe = mem_we & rst;
  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with directed instruction vectors
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, more;
  logic        PCWr, IRWr, alusrc, regwe, memwe, turn;
  logic [1:0]  regdst, memtoreg, branch, jump, extop, aluop;
  logic [3:0]  state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .more(more),
    .PCWr(PCWr), .IRWr(IRWr), .regdst(regdst), .alusrc(alusrc),
    .memtoreg(memtoreg), .regwe(regwe), .memwe(memwe), .branch(branch),
    .jump(jump), .extop(extop), .aluop(aluop), .turn(turn), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr;
    logic       irwr;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic       regwe;
    logic       memwe;
    logic [1:0] branch;
    logic [1:0] jump;
    logic [1:0] extop;
    logic [1:0] aluop;
    logic       turn;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: one expected observation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {state, PCWr, IRWr, regdst, alusrc, memtoreg, regwe, memwe,
           branch, jump, extop, aluop, turn};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got state=%0d fields=%h, expected state=%0d fields=%h",
                 t, a.st, a[17:0], e.st, e[17:0]);
      end
    end
  end

  task automatic ex(input string t, input logic [3:0] st, input logic pcwr, input logic irwr,
                    input logic [1:0] rd, input logic asrc, input logic [1:0] m2r,
                    input logic rwe, input logic mwe, input logic [1:0] br,
                    input logic [1:0] jp, input logic [1:0] ext, input logic [1:0] aop,
                    input logic trn);
    obs_t e;
    e = {st, pcwr, irwr, rd, asrc, m2r, rwe, mwe, br, jp, ext, aop, trn};
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic e_reset(input string t);
    ex(t, 4'd0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endtask
  task automatic e_fetch(input string t);
    ex({t, ".fetch"}, 4'd0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endtask
  task automatic e_decode(input string t);
    ex({t, ".decode"}, 4'd1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endtask
  task automatic e_memadr(input string t);
    ex({t, ".memadr"}, 4'd4, 0, 0, 2'b00, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
  endtask

  // Drive an instruction word and let it run for n cycles starting in FETCH
  task automatic issue(input logic [31:0] iw, input int n);
    instr = iw;
    zero  = iw[0];
    more  = iw[1];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input string t, input logic [31:0] iw, input logic [1:0] rd,
                        input logic asrc, input logic [1:0] ext, input logic [1:0] aop);
    e_fetch(t);
    e_decode(t);
    ex({t, ".exe"},   4'd2, 0, 0, 2'b00, asrc, 2'b00, 0, 0, 2'b00, 2'b00, ext, aop, 0);
    ex({t, ".aluwb"}, 4'd3, 0, 0, rd,    asrc, 2'b00, 1, 0, 2'b00, 2'b00, ext, aop, 0);
    issue(iw, 4);
  endtask

  task automatic do_load(input string t, input logic [31:0] iw);
    e_fetch(t);
    e_decode(t);
    e_memadr(t);
    ex({t, ".memrd"}, 4'd5, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    ex({t, ".memwb"}, 4'd6, 0, 0, 2'b00, 0, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    issue(iw, 5);
  endtask

  task automatic do_store(input string t, input logic [31:0] iw);
    e_fetch(t);
    e_decode(t);
    e_memadr(t);
    ex({t, ".memwr"}, 4'd7, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    issue(iw, 4);
  endtask

  task automatic do_branch(input string t, input logic [31:0] iw, input logic [1:0] br);
    e_fetch(t);
    e_decode(t);
    ex({t, ".branch"}, 4'd8, 1, 0, 2'b00, 0, 2'b00, 0, 0, br, 2'b00, 2'b00, 2'b01, 1);
    issue(iw, 3);
  endtask

  task automatic do_jump(input string t, input logic [31:0] iw, input logic link);
    e_fetch(t);
    e_decode(t);
    if (link)
      ex({t, ".jump"}, 4'd9, 1, 0, 2'b10, 0, 2'b10, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 1);
    else
      ex({t, ".jump"}, 4'd9, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 1);
    issue(iw, 3);
  endtask

  task automatic do_jr(input string t, input logic [31:0] iw);
    e_fetch(t);
    e_decode(t);
    ex({t, ".jrexe"}, 4'd10, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    ex({t, ".jr"},    4'd11, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1);
    issue(iw, 4);
  endtask

  task automatic do_illegal(input string t, input logic [31:0] iw);
    e_fetch(t);
    e_decode(t);
    issue(iw, 2);
  endtask

  initial begin
    int waited;
    rst   = 1'b0;
    instr = 32'h0000_0000;
    zero  = 1'b0;
    more  = 1'b0;
    e_reset("reset.c0");
    e_reset("reset.c1");
    e_reset("reset.c2");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;

    do_alu("addu",  32'h0022_1821, 2'b01, 1'b0, 2'b00, 2'b00);
    do_alu("subu",  32'h0022_1823, 2'b01, 1'b0, 2'b00, 2'b01);
    do_alu("slt",   32'h0022_182A, 2'b01, 1'b0, 2'b00, 2'b11);
    do_alu("addiu", 32'h2441_0005, 2'b00, 1'b1, 2'b01, 2'b00);
    do_alu("ori",   32'h3441_0005, 2'b00, 1'b1, 2'b00, 2'b10);
    do_alu("lui",   32'h3C01_1234, 2'b00, 1'b1, 2'b10, 2'b00);
    do_load("lb",   32'h8041_0004);
    do_load("lhu",  32'h9441_0002);
    do_load("lw",   32'h8C41_0000);
    do_store("sw",  32'hAC41_0008);
    do_store("sh",  32'hA441_0002);
    do_branch("beq",  32'h1022_0003, 2'b01);
    do_branch("bgtz", 32'h1C20_0003, 2'b10);
    do_jump("j",   32'h0800_0010, 1'b0);
    do_jump("jal", 32'h0C00_0010, 1'b1);
    do_jr("jr",    32'h03E0_0008);
    do_illegal("op3f",   32'hFC00_0000);
    do_illegal("badfn",  32'h0022_1800);

    // sw aborted by reset while in MEMWR: enables drop and state returns to FETCH at once
    e_fetch("swabort");
    e_decode("swabort");
    e_memadr("swabort");
    e_reset("swabort.rst0");
    e_reset("swabort.rst1");
    instr = 32'hAC41_0008;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    do_illegal("after_rst", 32'hFC00_0000);
    do_alu("addu2", 32'h0022_1821, 2'b01, 1'b0, 2'b00, 2'b00);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected observations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
